// File: rtl/iram_prog_loader_if.sv
// Byte-stream receive and IRAM write-port bundle for iram_prog_loader.
// The master side is the loader: it consumes stream bytes and drives the write port.
interface iram_prog_loader_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  modport master (
    input  rx_byte, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output rx_byte, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/iram_prog_loader.sv
// Streams a big-endian length-prefixed program image into the IRAM while holding the cores halted.
// Define LOADER_CHECKSUM_EN to require a trailing 16-bit sum-of-words checksum before DONE.
module iram_prog_loader #(
  parameter int DEPTH = 1025,
  parameter int BASE  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  iram_prog_loader_if.master  bus,
  output logic                cores_hold,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         word_cnt
);

  localparam int unsigned MAX_WORDS = DEPTH - BASE;
  localparam logic [15:0] BASE_ADDR = 16'(BASE);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM_HI, CSUM_LO, DONE, ERR
  } state_t;

  state_t      state;
  logic [15:0] len;
  logic [7:0]  data_hi;
  logic        take;
  logic [15:0] len_rx;
  logic [15:0] cnt_next;
  logic        too_long;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum;
  logic [7:0]  csum_hi;
`endif

  assign take     = bus.rx_valid & bus.rx_ready;
  assign len_rx   = {len[15:8], bus.rx_byte};
  assign cnt_next = word_cnt + 16'd1;
  assign too_long = 32'(len_rx) > MAX_WORDS;

  // rx_ready and the status flags are set on the transition into each state so they stay registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      len         <= '0;
      data_hi     <= '0;
      bus.rx_ready <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      cores_hold  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      word_cnt    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= '0;
      csum_hi     <= '0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN_HI;
            len          <= '0;
            bus.rx_ready <= 1'b1;
            cores_hold   <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            word_cnt     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end
        LEN_HI: begin
          if (take) begin
            len[15:8] <= bus.rx_byte;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (take) begin
            len <= len_rx;
            if (len_rx == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state        <= CSUM_HI;
`else
              state        <= DONE;
              bus.rx_ready <= 1'b0;
              busy         <= 1'b0;
              cores_hold   <= 1'b0;
              done         <= 1'b1;
`endif
            end else if (too_long) begin
              state        <= ERR;
              bus.rx_ready <= 1'b0;
              busy         <= 1'b0;
              error        <= 1'b1;
            end else begin
              state <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (take) begin
            data_hi <= bus.rx_byte;
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (take) begin
            bus.wr_en    <= 1'b1;
            bus.wr_addr  <= BASE_ADDR + word_cnt;
            bus.wr_data  <= {data_hi, bus.rx_byte};
            bus.rx_ready <= 1'b0;
            state        <= WRITE;
          end
        end
        WRITE: begin
          word_cnt <= cnt_next;
`ifdef LOADER_CHECKSUM_EN
          csum     <= csum + bus.wr_data;
`endif
          if (cnt_next == len) begin
`ifdef LOADER_CHECKSUM_EN
            state        <= CSUM_HI;
            bus.rx_ready <= 1'b1;
`else
            state        <= DONE;
            busy         <= 1'b0;
            cores_hold   <= 1'b0;
            done         <= 1'b1;
`endif
          end else begin
            state        <= DATA_HI;
            bus.rx_ready <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM_HI: begin
          if (take) begin
            csum_hi <= bus.rx_byte;
            state   <= CSUM_LO;
          end
        end
        CSUM_LO: begin
          if (take) begin
            bus.rx_ready <= 1'b0;
            busy         <= 1'b0;
            if ({csum_hi, bus.rx_byte} == csum) begin
              state      <= DONE;
              cores_hold <= 1'b0;
              done       <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state        <= IDLE;
          bus.rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
